// File: rtl/viterbi_dec_block.sv
`default_nettype none
// ============================================================================
// Module      : viterbi_dec_block
// Description : Block Viterbi decoder for a rate-1/2 convolutional code with
//               constraint length K. Accepts N hard-decision symbol pairs, one
//               per cycle, with a fully parallel add-compare-select. Then it
//               traces back one step per cycle and presents the N decoded bits
//               with the winning path metric.
// Ports       : clk        - rising-edge clock
//               reset      - synchronous, active-high
//               in_valid   - in_sym is valid
//               in_ready   - decoder accepts a symbol (ACS phase only)
//               in_sym     - received pair {G0 output, G1 output}
//               out_valid  - decoded block available
//               out_ready  - downstream accepts the block
//               out_data   - decoded bits, bit N-1 is the first decoded bit
//               out_metric - path metric of the traceback start state
// Revision    : 1.0 - initial release
// ============================================================================
module viterbi_dec_block #(
    parameter int             K    = 3,
    parameter int             N    = 7,
    parameter logic [K-1:0]   G0   = K'(3'b111),
    parameter logic [K-1:0]   G1   = K'(3'b101),
    parameter int             MW   = 8,
    parameter int             TERM = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [1:0]    in_sym,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  out_data,
    output logic [MW-1:0] out_metric
);

    localparam int          c_S   = 1 << (K - 1);
    localparam int          c_SW  = K - 1;
    localparam int          c_CW  = (N > 1) ? $clog2(N) : 1;
    localparam logic [MW-1:0] c_MAX = {MW{1'b1}};

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_ACS  = 2'd1;
    localparam logic [1:0] c_TB   = 2'd2;
    localparam logic [1:0] c_OUT  = 2'd3;

    logic [1:0]      r_state;
    logic [1:0]      w_next;
    logic [MW-1:0]   r_metric [c_S];
    logic [MW-1:0]   w_new    [c_S];
    logic [c_S-1:0]  w_dec;
    logic [c_S-1:0]  r_dec    [N];
    logic [c_CW-1:0] r_cnt;
    logic [c_CW-1:0] r_step;
    logic            r_tb_first;
    logic [c_SW-1:0] r_tb_state;
    logic [c_SW-1:0] w_min_idx;
    logic [MW-1:0]   w_min_val;
    logic [c_SW-1:0] w_start;
    logic [N-1:0]    r_data;
    logic [MW-1:0]   r_metric_out;
    logic            w_accept;
    logic            w_last;
    logic [c_CW-1:0] w_bit_idx;

    assign w_accept  = (r_state == c_ACS) && in_valid;
    assign w_last    = (r_cnt == c_CW'(N - 1));
    assign w_bit_idx = c_CW'(N - 1) - r_step;

    // ------------------------------------------------------------------
    // Add-compare-select, one unit per destination state. The predecessors
    // of s' are {s'[K-3:0], b}; the input bit driving the transition is the
    // MSB of s', so the expected symbol of each branch is a constant.
    // ------------------------------------------------------------------
    for (genvar sp = 0; sp < c_S; sp++) begin : g_acs
        localparam int          c_P0 = (sp * 2) % c_S;
        localparam int          c_P1 = c_P0 + 1;
        localparam int          c_U  = sp / (c_S / 2);
        localparam logic [K-1:0] c_R0 = K'(c_U * c_S + c_P0);
        localparam logic [K-1:0] c_R1 = K'(c_U * c_S + c_P1);
        localparam logic [1:0]  c_E0 = {^(G0 & c_R0), ^(G1 & c_R0)};
        localparam logic [1:0]  c_E1 = {^(G0 & c_R1), ^(G1 & c_R1)};

        logic [1:0]    w_x0, w_x1;
        logic [MW:0]   w_sum0, w_sum1;
        logic [MW-1:0] w_c0, w_c1;

        assign w_x0   = in_sym ^ c_E0;
        assign w_x1   = in_sym ^ c_E1;
        // Hamming distance of two bits is {AND, XOR} of the difference bits.
        assign w_sum0 = {1'b0, r_metric[c_P0]} + {{(MW-1){1'b0}}, w_x0[1] & w_x0[0], w_x0[1] ^ w_x0[0]};
        assign w_sum1 = {1'b0, r_metric[c_P1]} + {{(MW-1){1'b0}}, w_x1[1] & w_x1[0], w_x1[1] ^ w_x1[0]};
        assign w_c0   = w_sum0[MW] ? c_MAX : w_sum0[MW-1:0];
        assign w_c1   = w_sum1[MW] ? c_MAX : w_sum1[MW-1:0];
        // Strict compare so a tie keeps the b=0 predecessor.
        assign w_dec[sp] = (w_c1 < w_c0);
        assign w_new[sp] = w_dec[sp] ? w_c1 : w_c0;
    end

    // Lowest-index state holding the minimum metric.
    always_comb begin
        w_min_idx = '0;
        w_min_val = r_metric[0];
        for (int i = 1; i < c_S; i++) begin
            if (r_metric[i] < w_min_val) begin
                w_min_val = r_metric[i];
                w_min_idx = c_SW'(i);
            end
        end
        w_start = (TERM != 0) ? '0 : w_min_idx;
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) r_state <= c_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            c_IDLE: w_next = c_ACS;
            c_ACS: begin
                in_ready = 1'b1;
                if (in_valid && w_last) w_next = c_TB;
            end
            // The first TB cycle only selects the start state; N stepping
            // cycles follow.
            c_TB: if (!r_tb_first && (r_step == '0)) w_next = c_OUT;
            c_OUT: begin
                out_valid = 1'b1;
                if (out_ready) w_next = c_IDLE;
            end
            default: w_next = c_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Metrics, counters and traceback datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < c_S; i++) r_metric[i] <= (i == 0) ? '0 : c_MAX;
            r_cnt        <= '0;
            r_step       <= '0;
            r_tb_first   <= 1'b0;
            r_tb_state   <= '0;
            r_data       <= '0;
            r_metric_out <= '0;
        end else begin
            case (r_state)
                c_IDLE: r_cnt <= '0;
                c_ACS: begin
                    if (in_valid) begin
                        for (int i = 0; i < c_S; i++) r_metric[i] <= w_new[i];
                        if (w_last) begin
                            r_cnt      <= '0;
                            r_tb_first <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                c_TB: begin
                    if (r_tb_first) begin
                        r_tb_first   <= 1'b0;
                        r_tb_state   <= w_start;
                        r_metric_out <= r_metric[w_start];
                        r_step       <= c_CW'(N - 1);
                    end else begin
                        r_data[w_bit_idx] <= r_tb_state[c_SW-1];
                        r_tb_state <= {r_tb_state[K-3:0], r_dec[r_step][r_tb_state]};
                        if (r_step != '0) r_step <= r_step - 1'b1;
                    end
                end
                c_OUT: begin
                    if (out_ready) begin
                        for (int i = 0; i < c_S; i++) r_metric[i] <= (i == 0) ? '0 : c_MAX;
                    end
                end
                default: ;
            endcase
        end
    end

    // Survivor memory has no reset; it is always fully rewritten before use.
    always_ff @(posedge clk) begin
        if (w_accept) r_dec[r_cnt] <= w_dec;
    end

    assign out_data   = r_data;
    assign out_metric = r_metric_out;

endmodule
`default_nettype wire

// File: doc/viterbi_dec_block.md
VITERBI_DEC_BLOCK -- requirements
Module: viterbi_dec_block

Interface
REQ-001 The parameter K SHALL default to 3 and set the constraint length; the decoder has S = 2^(K-1) states, and K SHALL lie in the range 3..7.
REQ-002 The parameter N SHALL default to 7 and set the number of symbol pairs per block, which is also the number of decoded bits.
REQ-003 The parameters G0 and G1 SHALL default to K'b111 and K'b101 and are the generator polynomials; the MSB of each taps the current input bit.
REQ-004 The parameter MW SHALL default to 8 and set the path-metric width, and MW SHALL satisfy 2^MW - 1 > 2N.
REQ-005 The parameter TERM SHALL default to 1; 1 means traceback starts at state 0, and 0 means traceback starts at the minimum-metric state.
REQ-006 The design SHALL use one clock; reset is synchronous and active-high.
REQ-007 Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  in_sym is valid.
- in_ready  out  1  ready to accept a symbol.
- in_sym  in  2  received pair; bit1 is the G0 output and bit0 is the G1 output.
- out_valid  out  1  a decoded block is available.
- out_ready  in  1  downstream accepts the block.
- out_data  out  N  decoded bits; bit N-1 is the first decoded bit.
- out_metric  out  MW  final path metric, equal to the corrected Hamming distance.

Function
REQ-008 The encoder model SHALL be as follows.
- A state is s = {u(t-1) .. u(t-K+1)}, with the newest bit in the MSB.
- For input bit u, the encoder register is r = {u, s}.
- The outputs are c0 = XOR-reduce(G0 & r) and c1 = XOR-reduce(G1 & r).
- The next state is {u, s[K-2:1]}.
REQ-009 The FSM SHALL have the states IDLE, ACS, TB and OUT; reset SHALL place it in IDLE.
REQ-010 On reset entry, the path metrics SHALL be initialised: state 0 = 0 and every other state = 2^MW-1.
REQ-011 IDLE SHALL move to ACS on the next edge, with the symbol count cleared.
REQ-012 In ACS, in_ready SHALL be 1, and a symbol is accepted on each edge where in_valid=1.
REQ-013 Each accepted symbol SHALL update all S metrics on that same edge (one symbol per cycle, fully parallel ACS).
REQ-014 Each branch metric SHALL be the Hamming distance (0..2) between in_sym and {c0,c1}.
REQ-015 Each additive step SHALL saturate at 2^MW-1.
REQ-016 The predecessors of state s' SHALL be {s'[K-3:0], b} for b in {0,1}.
REQ-017 ACS SHALL keep the smaller candidate metric; on a tie it SHALL keep b=0. The survivor bit b SHALL be stored per state per step in an N x S decision array.
REQ-018 On the edge that accepts the Nth symbol, the FSM SHALL move to TB.
REQ-019 The TB start state SHALL be state 0 if TERM=1. If TERM=0, it SHALL be the lowest-index state among those with the minimum metric.
REQ-020 out_metric SHALL capture the metric of the TB start state.
REQ-021 TB SHALL process one step per cycle, from step N-1 down to step 0.
- The decoded bit for the step is the MSB of the current state.
- The next state is {cur[K-3:0], decision[step][cur]}.
REQ-022 After N TB cycles, the FSM SHALL enter OUT with out_valid=1.
- out_valid therefore rises exactly N+1 edges after the edge that accepted the Nth symbol.
REQ-023 out_data and out_metric SHALL be stable whenever out_valid=1.
REQ-024 In OUT, the block SHALL hold until out_valid and out_ready are both 1 on an edge, and then return to IDLE with the metrics re-initialised per REQ-010.
REQ-025 in_ready SHALL be 0 in IDLE, TB and OUT; in_valid SHALL be ignored outside ACS.
REQ-026 If in_valid=0 during ACS, the metrics and count SHALL be held (a stall).

Reset
REQ-027 The following SHALL hold on the cycle after any edge where reset=1, regardless of FSM state, including mid-ACS and mid-TB:
- state=IDLE
- in_ready=0
- out_valid=0
- out_data=0
- out_metric=0
- symbol count=0
- metrics per REQ-010
REQ-028 Any partially received or partially traced-back block SHALL be discarded on reset, with no output produced.
REQ-029 The decision array does not need to be cleared on reset.

Verification
REQ-030 A bench SHALL cover the following scenarios with the default parameters:
- Error-free block: in_sym = 11,10,00,01,01,11,00 back-to-back (0x385C packed MSB-first) -> out_data=7'b1011000, out_metric=0, out_valid rises 8 edges after the last accept.
- Single error: 11,10,00,11,01,11,00 -> out_data=7'b1011000, out_metric=1.
- Two separated errors: 01,10,00,01,01,10,00 -> out_data=7'b1011000, out_metric=2.
- Stalls plus backpressure: in_valid toggling 1/0 and out_ready held 0 for 5 cycles in OUT -> results identical to the error-free case, out_data stable throughout the stall, then one handshake and a return to ACS.
- Reset mid-TB, asserted on TB cycle 3 -> no out_valid; the next error-free block decodes correctly.
- TERM=0 with the error-free block -> out_data=7'b1011000 and out_metric=0, and the start state is 0 because it is the only zero-metric state.
